icache_ctrl: RTL and testbench

ICACHE_CTRL -- requirements
Module: icache_ctrl

---
 rtl/icache_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_icache_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : icache_ctrl                                                      |
// | Brief   : Two-thread instruction-cache tag controller with round-robin     |
// |           arbitration, external tag RAM lookup and line refill.            |
// |           Optional macro ICACHE_FLUSH_EN adds a Flush input.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module icache_ctrl #(
  parameter  int LINE_WORDS = 4,
  parameter  int SETS       = 128,
  localparam int OFF_W      = $clog2(LINE_WORDS),
  localparam int IDX_W      = $clog2(SETS),
  localparam int TAG_W      = 16 - IDX_W - OFF_W
) (
  input  logic             clk,
  input  logic             Reset,
`ifdef ICACHE_FLUSH_EN
  input  logic             Flush,
`endif
  input  logic [1:0]       FetchReq,
  input  logic [15:0]      FetchAddr0,
  input  logic [15:0]      FetchAddr1,
  output logic [1:0]       FetchDone,
  output logic             Enable,
  output logic [IDX_W-1:0] CacheIndexRead,
  input  logic [TAG_W-1:0] TagCompare,
  output logic             WriteTag,
  output logic [IDX_W-1:0] CacheIndexWrite,
  output logic [TAG_W-1:0] WriteAddressTag,
  output logic             MemReq,
  output logic [15:0]      MemAddr,
  input  logic             MemAck,
  output logic             DataWrite
);

  localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    COMPARE   = 3'd2,
    REFILL    = 3'd3,
    WRITE_TAG = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_thread;
  logic             r_prio;
  logic [TAG_W-1:0] r_tag;
  logic [IDX_W-1:0] r_idx;
  logic [OFF_W-1:0] r_cnt;
  logic [SETS-1:0]  r_valid;
  logic [1:0]       r_done;
  logic             r_enable;
  logic [IDX_W-1:0] r_idx_rd;
  logic             r_wtag;
  logic [IDX_W-1:0] r_idx_wr;
  logic [TAG_W-1:0] r_tag_wr;
  logic             r_memreq;
  logic [15:0]      r_memaddr;
`ifdef ICACHE_FLUSH_EN
  logic             r_flush_pend;
`endif

  logic [1:0]       w_req;
  logic             w_any;
  logic             w_grant_t1;
  logic [15:0]      w_addr;
  logic             w_hit;
  logic [OFF_W-1:0] w_cnt_nxt;
  logic             w_unused_off;

  // A thread whose FetchDone is on this cycle still shows its request; mask it.
  assign w_req        = FetchReq & ~r_done;
  assign w_any        = |w_req;
  assign w_grant_t1   = w_req[1] & (~w_req[0] | r_prio);
  assign w_addr       = w_grant_t1 ? FetchAddr1 : FetchAddr0;
  assign w_hit        = (TagCompare == r_tag) && r_valid[r_idx];
  assign w_cnt_nxt    = r_cnt + 1'b1;
  assign w_unused_off = ^w_addr[OFF_W-1:0];

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_thread  <= 1'b0;
      r_prio    <= 1'b0;
      r_tag     <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_valid   <= '0;
      r_done    <= '0;
      r_enable  <= 1'b0;
      r_idx_rd  <= '0;
      r_wtag    <= 1'b0;
      r_idx_wr  <= '0;
      r_tag_wr  <= '0;
      r_memreq  <= 1'b0;
      r_memaddr <= '0;
`ifdef ICACHE_FLUSH_EN
      r_flush_pend <= 1'b0;
`endif
    end else begin
      r_done   <= '0;
      r_enable <= 1'b0;
      r_idx_rd <= '0;
      r_wtag   <= 1'b0;
      r_idx_wr <= '0;
      r_tag_wr <= '0;
`ifdef ICACHE_FLUSH_EN
      if (Flush && (r_state != IDLE)) r_flush_pend <= 1'b1;
`endif
      case (r_state)
        IDLE: begin
`ifdef ICACHE_FLUSH_EN
          if (Flush || r_flush_pend) begin
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
          end else
`endif
          if (w_any) begin
            r_thread <= w_grant_t1;
            r_prio   <= ~w_grant_t1;
            r_tag    <= w_addr[15 -: TAG_W];
            r_idx    <= w_addr[OFF_W +: IDX_W];
            r_enable <= 1'b1;
            r_idx_rd <= w_addr[OFF_W +: IDX_W];
            r_state  <= LOOKUP;
          end
        end
        LOOKUP: r_state <= COMPARE;
        COMPARE: begin
          if (w_hit) begin
            r_done[r_thread] <= 1'b1;
            r_state          <= IDLE;
          end else begin
            r_cnt     <= '0;
            r_memreq  <= 1'b1;
            r_memaddr <= {r_tag, r_idx, {OFF_W{1'b0}}};
            r_state   <= REFILL;
          end
        end
        REFILL: begin
          if (MemAck) begin
            r_cnt <= w_cnt_nxt;
            if (r_cnt == CNT_LAST) begin
              r_memreq  <= 1'b0;
              r_memaddr <= '0;
              r_wtag    <= 1'b1;
              r_idx_wr  <= r_idx;
              r_tag_wr  <= r_tag;
              r_state   <= WRITE_TAG;
            end else begin
              r_memaddr <= {r_tag, r_idx, w_cnt_nxt};
            end
          end
        end
        WRITE_TAG: begin
          // Replay the lookup; the freshly written tag makes it hit.
          r_valid[r_idx] <= 1'b1;
          r_enable       <= 1'b1;
          r_idx_rd       <= r_idx;
          r_state        <= LOOKUP;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign FetchDone       = r_done;
  assign Enable          = r_enable;
  assign CacheIndexRead  = r_idx_rd;
  assign WriteTag        = r_wtag;
  assign CacheIndexWrite = r_idx_wr;
  assign WriteAddressTag = r_tag_wr;
  assign MemReq          = r_memreq;
  assign MemAddr         = r_memaddr;
  assign DataWrite       = r_memreq & MemAck;

endmodule
`default_nettype wire

// File: tb/tb_icache_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_icache_ctrl                                                   |
// | Brief   : Directed self-checking bench for icache_ctrl (tag RAM and refill |
// |           memory modelled here). Honours ICACHE_FLUSH_EN.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_icache_ctrl;

  logic        clk = 1'b0;
  logic        Reset;
  logic [1:0]  FetchReq;
  logic [15:0] FetchAddr0, FetchAddr1;
  logic [1:0]  FetchDone;
  logic        Enable;
  logic [6:0]  CacheIndexRead;
  logic [6:0]  TagCompare;
  logic        WriteTag;
  logic [6:0]  CacheIndexWrite;
  logic [6:0]  WriteAddressTag;
  logic        MemReq;
  logic [15:0] MemAddr;
  logic        MemAck;
  logic        DataWrite;
`ifdef ICACHE_FLUSH_EN
  logic        Flush;
`endif

  always #5 clk = ~clk;

  icache_ctrl #(.LINE_WORDS(4), .SETS(128)) u_dut (
    .clk             (clk),
    .Reset           (Reset),
`ifdef ICACHE_FLUSH_EN
    .Flush           (Flush),
`endif
    .FetchReq        (FetchReq),
    .FetchAddr0      (FetchAddr0),
    .FetchAddr1      (FetchAddr1),
    .FetchDone       (FetchDone),
    .Enable          (Enable),
    .CacheIndexRead  (CacheIndexRead),
    .TagCompare      (TagCompare),
    .WriteTag        (WriteTag),
    .CacheIndexWrite (CacheIndexWrite),
    .WriteAddressTag (WriteAddressTag),
    .MemReq          (MemReq),
    .MemAddr         (MemAddr),
    .MemAck          (MemAck),
    .DataWrite       (DataWrite)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // External tag RAM: one-cycle read latency after Enable.
  logic [6:0] tagmem [128];
  always @(posedge clk) begin
    if (WriteTag) tagmem[CacheIndexWrite] <= WriteAddressTag;
    if (Enable)   TagCompare <= tagmem[CacheIndexRead];
  end

  // Refill memory: two idle cycles, then an ack, per word.
  bit resp_en   = 1'b1;
  bit resp_wait = 1'b0;
  always @(posedge clk) begin
    #1;
    if (resp_en) begin
      if (MemAck) begin
        MemAck    = 1'b0;
        resp_wait = 1'b0;
      end else if (MemReq) begin
        if (resp_wait) begin
          MemAck    = 1'b1;
          resp_wait = 1'b0;
        end else begin
          resp_wait = 1'b1;
        end
      end
    end
  end

  int          ack_cnt = 0;
  int          wt_cnt  = 0;
  int          req_cyc = 0;
  logic [15:0] addr_q[$];
  logic [6:0]  wt_idx, wt_tag;
  int          done_q[$];
  always @(negedge clk) begin
    if (DataWrite) begin
      ack_cnt++;
      addr_q.push_back(MemAddr);
    end
    if (MemReq) req_cyc++;
    if (WriteTag) begin
      wt_cnt++;
      wt_idx = CacheIndexWrite;
      wt_tag = WriteAddressTag;
    end
    if (FetchDone[0]) done_q.push_back(0);
    if (FetchDone[1]) done_q.push_back(1);
  end

  function automatic logic [63:0] all_outs();
    return {21'b0, FetchDone, Enable, CacheIndexRead, WriteTag, CacheIndexWrite,
            WriteAddressTag, MemReq, MemAddr, DataWrite};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Reset    = 1'b1;
    FetchReq = 2'b00;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  // Single-thread fetch; cyc counts edges from the grant edge to FetchDone.
  task automatic fetch(input string tag, input int th, input logic [15:0] a, output int cyc);
    if (th == 0) FetchAddr0 = a; else FetchAddr1 = a;
    FetchReq[th] = 1'b1;
    cyc = 0;
    while (!FetchDone[th] && cyc < 300) begin
      tick();
      cyc++;
    end
    check_eq({tag, "_done"}, 64'(FetchDone[th]), 64'd1);
    FetchReq[th] = 1'b0;
    tick();
    check_eq({tag, "_pulse"}, 64'(FetchDone[th]), 64'd0);
  endtask

  task automatic fetch_both(input string tag, input logic [15:0] a0, input logic [15:0] a1,
                            output int first);
    int cyc;
    FetchAddr0 = a0;
    FetchAddr1 = a1;
    done_q.delete();
    FetchReq = 2'b11;
    cyc = 0;
    while (FetchReq != 2'b00 && cyc < 600) begin
      tick();
      cyc++;
      if (FetchDone[0]) FetchReq[0] = 1'b0;
      if (FetchDone[1]) FetchReq[1] = 1'b0;
    end
    FetchReq = 2'b00;
    tick();
    check_eq({tag, "_ndone"}, 64'(done_q.size()), 64'd2);
    first = (done_q.size() > 0) ? done_q[0] : -1;
    if (done_q.size() > 1)
      check_eq({tag, "_second"}, 64'(done_q[1]), 64'(1 - first));
  endtask

  initial begin
    int cyc, base, rbase, wbase, first;
    Reset      = 1'b1;
    FetchReq   = 2'b00;
    FetchAddr0 = 16'h0;
    FetchAddr1 = 16'h0;
    MemAck     = 1'b0;
`ifdef ICACHE_FLUSH_EN
    Flush      = 1'b0;
`endif
    tick();
    tick();
    check_eq("reset_outs", all_outs(), 64'd0);
    Reset = 1'b0;
    tick();
    check_eq("post_reset_outs", all_outs(), 64'd0);

    // Cold miss on 0x1234
    base = ack_cnt; wbase = wt_cnt; addr_q.delete();
    fetch("miss1234", 0, 16'h1234, cyc);
    check_eq("miss_acks", 64'(ack_cnt - base), 64'd4);
    check_eq("miss_naddr", 64'(addr_q.size()), 64'd4);
    for (int k = 0; k < 4 && k < addr_q.size(); k++)
      check_eq($sformatf("miss_addr%0d", k), 64'(addr_q[k]), 64'(16'h1234 + k));
    check_eq("miss_wt_cnt", 64'(wt_cnt - wbase), 64'd1);
    check_eq("miss_wt_idx", 64'(wt_idx), 64'h0D);
    check_eq("miss_wt_tag", 64'(wt_tag), 64'h09);

    // Repeat is a hit: done on the third edge after grant, no refill
    base = ack_cnt; rbase = req_cyc;
    fetch("hit1234", 0, 16'h1234, cyc);
    check_eq("hit_latency", 64'(cyc), 64'd3);
    check_eq("hit_acks", 64'(ack_cnt - base), 64'd0);
    check_eq("hit_memreq", 64'(req_cyc - rbase), 64'd0);

    // Arbitration from a fresh pointer
    do_reset();
    fetch_both("rr1", 16'h0000, 16'h0200, first);
    check_eq("rr1_first", 64'(first), 64'd0);
    base = ack_cnt;
    fetch("rr_t0", 0, 16'h0000, cyc);
    check_eq("rr_t0_miss", 64'(ack_cnt - base), 64'd4);
    fetch_both("rr2", 16'h0000, 16'h0200, first);
    check_eq("rr2_first", 64'(first), 64'd1);

    // Same index, different tag
    base = ack_cnt;
    fetch("c0004a", 0, 16'h0004, cyc);
    check_eq("c0004a_acks", 64'(ack_cnt - base), 64'd4);
    base = ack_cnt;
    fetch("c0204", 1, 16'h0204, cyc);
    check_eq("c0204_acks", 64'(ack_cnt - base), 64'd4);
    check_eq("c0204_wt_idx", 64'(wt_idx), 64'h01);
    check_eq("c0204_wt_tag", 64'(wt_tag), 64'h01);
    base = ack_cnt;
    fetch("c0004b", 0, 16'h0004, cyc);
    check_eq("c0004b_acks", 64'(ack_cnt - base), 64'd4);

    // Reset in the middle of a refill
    base = ack_cnt; wbase = wt_cnt;
    FetchAddr0  = 16'h1234;
    FetchReq[0] = 1'b1;
    cyc = 0;
    while (ack_cnt < base + 2 && cyc < 200) begin
      tick();
      cyc++;
    end
    check_eq("rst_pre_acks", 64'(ack_cnt - base), 64'd2);
    resp_en  = 1'b0;
    MemAck   = 1'b0;
    Reset    = 1'b1;
    FetchReq = 2'b00;
    tick();
    tick();
    check_eq("rst_mid_outs", all_outs(), 64'd0);
    Reset  = 1'b0;
    MemAck = 1'b1;
    tick();
    MemAck = 1'b0;
    tick();
    check_eq("rst_stray_ack_outs", all_outs(), 64'd0);
    check_eq("rst_no_wt", 64'(wt_cnt - wbase), 64'd0);
    resp_en = 1'b1;
    base = ack_cnt;
    fetch("rst_refetch", 0, 16'h1234, cyc);
    check_eq("rst_refetch_acks", 64'(ack_cnt - base), 64'd4);

`ifdef ICACHE_FLUSH_EN
    base = ack_cnt;
    fetch("fl_hit", 0, 16'h1234, cyc);
    check_eq("fl_hit_acks", 64'(ack_cnt - base), 64'd0);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    base = ack_cnt;
    fetch("fl_miss", 0, 16'h1234, cyc);
    check_eq("fl_miss_acks", 64'(ack_cnt - base), 64'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
